pipe_stage_skid: RTL

- Parametrised decode-to-execute pipeline stage register with a valid/ready handshake, stall and flush support, and a 2-entry skid buffer.
- Carries N operand words, an extended immediate, a destination register address (WA3) and a control bundle.
- Sits between the decode and execute stages.
- Replaces fixed-width, always-advancing stage registers so hazard logic can stall or squash a stage without losing data.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_payload_reg.sv | 33 +++
 rtl/pipe_stage_skid.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg: shared pipeline-stage types and payload sizing.  Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_ADDR_W = 4;

    // Encoding mirrors {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_e;

    function automatic int unsigned payload_width(input int unsigned num_ops,
                                                  input int unsigned data_w,
                                                  input int unsigned addr_w,
                                                  input int unsigned ctrl_w);
        return num_ops * data_w + data_w + addr_w + ctrl_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_payload_reg.sv
// ============================================================================
// pipe_payload_reg: payload register, async clear, load enable, sync clear.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_payload_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// pipe_stage_skid: decode->execute stage register with 2-entry skid buffer.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W        = PIPE_DATA_W,
    parameter int unsigned NUM_OPS       = 2,
    parameter int unsigned ADDR_W        = PIPE_ADDR_W,
    parameter int unsigned CTRL_W        = 8,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [DATA_W-1:0]         in_ext,
    input  logic [ADDR_W-1:0]         in_wa3,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [DATA_W-1:0]         out_ext,
    output logic [ADDR_W-1:0]         out_wa3,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [1:0]                occupancy
);

    localparam int unsigned PAYLOAD_W = payload_width(NUM_OPS, DATA_W, ADDR_W, CTRL_W);
    localparam int unsigned OPS_W     = NUM_OPS * DATA_W;

    stage_state_e         state_q, state_d;
    logic                 accept, emit;
    logic                 main_load, skid_load, pay_clear;
    logic [PAYLOAD_W-1:0] in_payload, main_payload, skid_payload, main_d;

    assign in_payload = {in_ctrl, in_wa3, in_ext, in_ops};

    // Handshake outputs come straight from the state register bits.
    assign in_ready  = ~state_q[0];
    assign out_valid = state_q[1];
    assign occupancy = 2'(state_q[1]) + 2'(state_q[0]);

    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign pay_clear = flush & ZERO_ON_FLUSH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Draining FULL promotes the skid entry; otherwise main takes fresh input.
    assign main_d = state_q[0] ? skid_payload : in_payload;

    pipe_payload_reg #(
        .W (PAYLOAD_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (main_load),
        .clear_i (pay_clear),
        .d_i     (main_d),
        .q_o     (main_payload)
    );

    pipe_payload_reg #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (skid_load),
        .clear_i (pay_clear),
        .d_i     (in_payload),
        .q_o     (skid_payload)
    );

    assign out_ops  = main_payload[OPS_W-1:0];
    assign out_ext  = main_payload[OPS_W +: DATA_W];
    assign out_wa3  = main_payload[OPS_W + DATA_W +: ADDR_W];
    assign out_ctrl = main_payload[PAYLOAD_W-1 -: CTRL_W];

endmodule

`default_nettype wire
